// File: rtl/decode_modrm.sv
// ModR/M byte decoder for the front-end decode stage. It produces the default segment,
// the base and index registers, the displacement size and the SIB flag, with one cycle of latency.
module decode_modrm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instruction,
    input  logic       w,
    input  logic [1:0] info_bit_width,
    output logic [2:0] info_segment_reg,
    output logic [4:0] info_base_reg,
    output logic [4:0] info_index_reg,
    output logic [1:0] info_displacement,
    output logic       sib_is_present
);
    localparam logic [2:0] SEG_SS = 3'd2;
    localparam logic [2:0] SEG_DS = 3'd3;
    localparam logic [1:0] DISP_NONE = 2'b00;
    localparam logic [1:0] DISP_8    = 2'b01;
    localparam logic [1:0] DISP_16   = 2'b10;
    localparam logic [1:0] DISP_32   = 2'b11;

    typedef struct packed {
        logic [2:0] seg;
        logic [4:0] base;
        logic [4:0] index;
        logic [1:0] disp;
        logic       sib;
    } dec_t;

    localparam dec_t DEC_RESET = '{seg: SEG_DS, base: 5'd0, index: 5'd0, disp: DISP_NONE, sib: 1'b0};

    // Valid, full-width register code.
    function automatic logic [4:0] gpr(input logic [2:0] r);
        return {2'b10, r};
    endfunction

    logic [1:0] mod_f;
    logic [2:0] rm_f;
    logic       a32;
    dec_t       dec_d, dec_q;

    assign mod_f = instruction[7:6];
    assign rm_f  = instruction[2:0];
    assign a32   = (info_bit_width == 2'b10);

    always_comb begin
        dec_d = DEC_RESET;
        if (mod_f == 2'b11) begin
            dec_d.base = {1'b1, ~w, rm_f};
        end else if (a32) begin
            dec_d.disp = (mod_f == 2'b01) ? DISP_8 : (mod_f == 2'b10) ? DISP_32 : DISP_NONE;
            if (rm_f == 3'd4) begin
                dec_d.sib = 1'b1;
            end else if (rm_f == 3'd5) begin
                // With mod=00, rm=101 means an absolute disp32 with no base register.
                if (mod_f == 2'b00) begin
                    dec_d.disp = DISP_32;
                end else begin
                    dec_d.base = gpr(3'd5);
                    dec_d.seg  = SEG_SS;
                end
            end else begin
                dec_d.base = gpr(rm_f);
            end
        end else begin
            dec_d.disp = (mod_f == 2'b01) ? DISP_8 : (mod_f == 2'b10) ? DISP_16 : DISP_NONE;
            case (rm_f)
                3'd0: begin dec_d.base = gpr(3'd3); dec_d.index = gpr(3'd6); end
                3'd1: begin dec_d.base = gpr(3'd3); dec_d.index = gpr(3'd7); end
                3'd2: begin dec_d.base = gpr(3'd5); dec_d.index = gpr(3'd6); dec_d.seg = SEG_SS; end
                3'd3: begin dec_d.base = gpr(3'd5); dec_d.index = gpr(3'd7); dec_d.seg = SEG_SS; end
                3'd4: dec_d.base = gpr(3'd6);
                3'd5: dec_d.base = gpr(3'd7);
                3'd6: begin
                    // With mod=00, rm=110 means an absolute disp16 in DS.
                    if (mod_f == 2'b00) begin
                        dec_d.disp = DISP_16;
                    end else begin
                        dec_d.base = gpr(3'd5);
                        dec_d.seg  = SEG_SS;
                    end
                end
                default: dec_d.base = gpr(3'd3);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dec_q <= DEC_RESET;
        else        dec_q <= dec_d;
    end

    assign info_segment_reg  = dec_q.seg;
    assign info_base_reg     = dec_q.base;
    assign info_index_reg    = dec_q.index;
    assign info_displacement = dec_q.disp;
    assign sib_is_present    = dec_q.sib;
endmodule

// File: tb/tb_decode_modrm.sv
// Scoreboard bench for decode_modrm. Each directed vector pushes its hand-computed expectation,
// and the monitor checks that expectation against the registered outputs one cycle later.
module tb_decode_modrm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instruction = 8'hFF;
    logic       w = 1'b0;
    logic [1:0] info_bit_width = 2'b01;
    logic [2:0] info_segment_reg;
    logic [4:0] info_base_reg;
    logic [4:0] info_index_reg;
    logic [1:0] info_displacement;
    logic       sib_is_present;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  stim_vld = 1'b0;
    logic  mon_vld = 1'b0;

    decode_modrm dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .w(w),
        .info_bit_width(info_bit_width), .info_segment_reg(info_segment_reg),
        .info_base_reg(info_base_reg), .info_index_reg(info_index_reg),
        .info_displacement(info_displacement), .sib_is_present(sib_is_present)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [2:0] seg, input logic [4:0] base,
                                       input logic [4:0] idx, input logic [1:0] disp, input logic sib);
        return {seg, base, idx, disp, sib};
    endfunction

    // Output sampled at the negedge after the capturing edge.
    always @(posedge clk) mon_vld <= stim_vld;

    always @(negedge clk) begin
        if (mon_vld) begin
            logic [15:0] act;
            act = {info_segment_reg, info_base_reg, info_index_reg, info_displacement, sib_is_present};
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow: output %h with no expectation queued", act);
            end else begin
                item_t it;
                it = q.pop_front();
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got seg=%b base=%b idx=%b disp=%b sib=%b, want seg=%b base=%b idx=%b disp=%b sib=%b",
                             it.name, act[15:13], act[12:8], act[7:3], act[2:1], act[0],
                             it.exp[15:13], it.exp[12:8], it.exp[7:3], it.exp[2:1], it.exp[0]);
                end
            end
        end
    end

    task automatic issue(input string name, input logic rst, input logic [7:0] ins,
                         input logic ww, input logic [1:0] bw, input logic [15:0] exp);
        item_t it;
        @(posedge clk);
        #1;
        rst_n = rst; instruction = ins; w = ww; info_bit_width = bw;
        stim_vld = 1'b1;
        it.name = name; it.exp = exp;
        q.push_back(it);
    endtask

    localparam logic [15:0] RST = {3'd3, 5'd0, 5'd0, 2'b00, 1'b0};

    initial begin
        issue("reset0", 1'b0, 8'hFF, 1'b1, 2'b10, RST);
        issue("reset1", 1'b0, 8'hFF, 1'b1, 2'b10, RST);
        issue("a32_sib_44",   1'b1, 8'h44, 1'b1, 2'b10, mk(3'd3, 5'd0, 5'd0, 2'b01, 1'b1));
        issue("a16_bxsi_40",  1'b1, 8'h40, 1'b1, 2'b01, mk(3'd3, 5'b10011, 5'b10110, 2'b01, 1'b0));
        issue("a16_abs_06",   1'b1, 8'h06, 1'b1, 2'b01, mk(3'd3, 5'd0, 5'd0, 2'b10, 1'b0));
        issue("a16_bp_46",    1'b1, 8'h46, 1'b1, 2'b01, mk(3'd2, 5'b10101, 5'd0, 2'b01, 1'b0));
        issue("a32_abs_05",   1'b1, 8'h05, 1'b1, 2'b10, mk(3'd3, 5'd0, 5'd0, 2'b11, 1'b0));
        issue("a32_ebp_85",   1'b1, 8'h85, 1'b1, 2'b10, mk(3'd2, 5'b10101, 5'd0, 2'b11, 1'b0));
        issue("rr16_ah_C4",   1'b1, 8'hC4, 1'b0, 2'b01, mk(3'd3, 5'b11100, 5'd0, 2'b00, 1'b0));
        issue("rr16_sp_C4",   1'b1, 8'hC4, 1'b1, 2'b01, mk(3'd3, 5'b10100, 5'd0, 2'b00, 1'b0));
        issue("rr32_ah_C4",   1'b1, 8'hC4, 1'b0, 2'b10, mk(3'd3, 5'b11100, 5'd0, 2'b00, 1'b0));
        issue("rr32_sp_C4",   1'b1, 8'hC4, 1'b1, 2'b10, mk(3'd3, 5'b10100, 5'd0, 2'b00, 1'b0));
        issue("a16_bpsi_8A",  1'b1, 8'h8A, 1'b1, 2'b01, mk(3'd2, 5'b10101, 5'b10110, 2'b10, 1'b0));
        issue("a16_bpsi_02",  1'b1, 8'h02, 1'b0, 2'b00, mk(3'd2, 5'b10101, 5'b10110, 2'b00, 1'b0));
        issue("a16_bxdi_01",  1'b1, 8'h01, 1'b1, 2'b01, mk(3'd3, 5'b10011, 5'b10111, 2'b00, 1'b0));
        issue("a16_bpdi_5B",  1'b1, 8'h5B, 1'b1, 2'b01, mk(3'd2, 5'b10101, 5'b10111, 2'b01, 1'b0));
        issue("a16_si_84",    1'b1, 8'h84, 1'b0, 2'b01, mk(3'd3, 5'b10110, 5'd0, 2'b10, 1'b0));
        issue("a16_bx_07",    1'b1, 8'h07, 1'b1, 2'b01, mk(3'd3, 5'b10011, 5'd0, 2'b00, 1'b0));
        issue("a16_regign_7F",1'b1, 8'h7F, 1'b1, 2'b01, mk(3'd3, 5'b10011, 5'd0, 2'b01, 1'b0));
        issue("bw11_di_05",   1'b1, 8'h05, 1'b1, 2'b11, mk(3'd3, 5'b10111, 5'd0, 2'b00, 1'b0));
        issue("a32_eax_00",   1'b1, 8'h00, 1'b1, 2'b10, mk(3'd3, 5'b10000, 5'd0, 2'b00, 1'b0));
        issue("a32_sib_84",   1'b1, 8'h84, 1'b1, 2'b10, mk(3'd3, 5'd0, 5'd0, 2'b11, 1'b1));
        issue("a32_sib_04",   1'b1, 8'h04, 1'b1, 2'b10, mk(3'd3, 5'd0, 5'd0, 2'b00, 1'b1));
        issue("a32_ebp_45",   1'b1, 8'h45, 1'b1, 2'b10, mk(3'd2, 5'b10101, 5'd0, 2'b01, 1'b0));
        issue("a32_edi_BF",   1'b1, 8'hBF, 1'b0, 2'b10, mk(3'd3, 5'b10111, 5'd0, 2'b11, 1'b0));
        issue("midreset_46",  1'b0, 8'h46, 1'b1, 2'b01, RST);
        issue("resume_46",    1'b1, 8'h46, 1'b1, 2'b01, mk(3'd2, 5'b10101, 5'd0, 2'b01, 1'b0));
        @(posedge clk);
        #1;
        stim_vld = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
